// File: rtl/drum_div_seq_if.sv
// Operand/result handshake bundle for drum_div_seq: valid/ready on the operand side and on the result side.
interface drum_div_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, r, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, r, div_by_zero
  );
endinterface

// File: rtl/drum_div_seq.sv
// Approximate DRUM-style unsigned divider: K-bit mantissas, radix-2 restoring divide, exponent re-shift.
// Latency 2K+2 cycles from accept (2 for zero operands); one op in flight, result held until out_ready.
// Optional DRUM_DIV_ROUND_EN: round-to-nearest (ties up) on right shifts instead of truncation.
module drum_div_seq #(
  parameter int WIDTH = 16,
  parameter int K     = 5
) (
  input  logic          clk,
  input  logic          rst,
  drum_div_seq_if.slave bus
);
  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(2 * K);
  localparam int EW = PW + 2;
  localparam int XW = WIDTH + 2 * K + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DIV,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_r;
  logic               r_dbz;
  logic               r_zero;
  logic [2*K-1:0]     r_n;
  logic [2*K-1:0]     r_q;
  logic [K-1:0]       r_mb;
  logic [K-1:0]       r_rem;
  logic [PW-1:0]      r_pa;
  logic [PW-1:0]      r_pb;
  logic [CW-1:0]      r_cnt;

  function automatic logic [PW-1:0] f_lead(input logic [WIDTH-1:0] x);
    logic [PW-1:0] k;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) k = PW'(i);
    end
    return k;
  endfunction

  function automatic logic [PW-1:0] f_exp(input logic [WIDTH-1:0] x);
    logic [PW-1:0] k;
    k = f_lead(x);
    return (k >= PW'(K)) ? (k - PW'(K - 1)) : '0;
  endfunction

  // Large operands keep their top K bits with the LSB forced to 1 to unbias the truncation.
  function automatic logic [K-1:0] f_mant(input logic [WIDTH-1:0] x, input logic [PW-1:0] p);
    return (p != '0) ? (K'(x >> p) | K'(1)) : x[K-1:0];
  endfunction

  logic [PW-1:0]  w_pa;
  logic [PW-1:0]  w_pb;
  logic           w_zero_op;
  logic [K:0]     w_rem_sh;
  logic           w_ge;
  logic [K-1:0]   w_sub;

  assign w_pa      = f_exp(r_a);
  assign w_pb      = f_exp(r_b);
  assign w_zero_op = (r_a == '0) || (r_b == '0);
  assign w_rem_sh  = {r_rem, r_n[2*K-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_mb});
  // Remainder after subtraction is below r_mb, so the low K bits carry it exactly.
  assign w_sub     = w_rem_sh[K-1:0] - r_mb;

  logic signed [EW-1:0] w_e;
  logic [EW-1:0]        w_sh;
  logic [XW-1:0]        w_qx;
  logic [XW-1:0]        w_res;
  logic [WIDTH-1:0]     w_shifted;

  assign w_e  = $signed({2'b00, r_pa}) - $signed({2'b00, r_pb}) - $signed(EW'(K));
  assign w_sh = w_e[EW-1] ? EW'(-w_e) : EW'(w_e);
  assign w_qx = XW'(r_q);

`ifdef DRUM_DIV_ROUND_EN
  logic [XW-1:0] w_rnd;
  assign w_rnd = w_e[EW-1] ? (XW'(1) << (w_sh - EW'(1))) : '0;
  assign w_res = w_e[EW-1] ? ((w_qx + w_rnd) >> w_sh) : (w_qx << w_sh);
`else
  assign w_res = w_e[EW-1] ? (w_qx >> w_sh) : (w_qx << w_sh);
`endif

  assign w_shifted = (|w_res[XW-1:WIDTH]) ? '1 : w_res[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_NORM;
      // Zero operands skip DIV; SHIFT then publishes the special-case result.
      S_NORM:  w_next = w_zero_op ? S_SHIFT : S_DIV;
      S_DIV:   if (r_cnt == CW'(2 * K - 1)) w_next = S_SHIFT;
      S_SHIFT: w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
      r_zero <= 1'b0;
      r_n    <= '0;
      r_q    <= '0;
      r_mb   <= '0;
      r_rem  <= '0;
      r_pa   <= '0;
      r_pb   <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a <= bus.a;
            r_b <= bus.b;
          end
        end
        S_NORM: begin
          r_zero <= w_zero_op;
          r_n    <= {f_mant(r_a, w_pa), K'(0)};
          r_mb   <= f_mant(r_b, w_pb);
          r_pa   <= w_pa;
          r_pb   <= w_pb;
          r_rem  <= '0;
          r_q    <= '0;
          r_cnt  <= '0;
        end
        S_DIV: begin
          r_n   <= r_n << 1;
          r_q   <= {r_q[2*K-2:0], w_ge};
          r_rem <= w_ge ? w_sub : w_rem_sh[K-1:0];
          r_cnt <= r_cnt + CW'(1);
        end
        S_SHIFT: begin
          if (r_zero) begin
            r_r   <= (r_b == '0) ? '1 : '0;
            r_dbz <= (r_b == '0);
          end else begin
            r_r   <= w_shifted;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.r           = r_r;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_drum_div_seq.sv
// Randomized bench for drum_div_seq against an arithmetic reference of the DRUM division rules.
module tb_drum_div_seq;
  localparam int WIDTH = 16;
  localparam int K     = 5;
  localparam int LAT   = 2 * K + 2;
`ifdef DRUM_DIV_ROUND_EN
  localparam logic [15:0] R_20_3 = 16'd7;
`else
  localparam logic [15:0] R_20_3 = 16'd6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  drum_div_seq_if #(.WIDTH(WIDTH)) bus ();

  drum_div_seq #(.WIDTH(WIDTH), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void norm(input logic [15:0] x, output int p, output int m);
    int k;
    k = 0;
    for (int i = 0; i < WIDTH; i++) if (x[i]) k = i;
    if (k >= K) begin
      p = k - K + 1;
      m = (int'(x) >> p) | 1;
    end else begin
      p = 0;
      m = int'(x);
    end
  endfunction

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic dbz);
    int pa, pb, ma, mb, e;
    longint q, res;
    dbz = (b == 16'd0);
    if (b == 16'd0) r = 16'hFFFF;
    else if (a == 16'd0) r = 16'd0;
    else begin
      norm(a, pa, ma);
      norm(b, pb, mb);
      q = (longint'(ma) * (longint'(1) << K)) / longint'(mb);
      e = pa - pb - K;
      if (e >= 0) res = q * (longint'(1) << e);
`ifdef DRUM_DIV_ROUND_EN
      else res = (q + (longint'(1) << (-e - 1))) >> (-e);
`else
      else res = q >> (-e);
`endif
      r = (res > 65535) ? 16'hFFFF : 16'(res);
    end
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_r,
                        input logic exp_dbz, input int exp_lat, input int hold,
                        output logic [15:0] got_r);
    int cnt;
    cnt = 0;
    while (!bus.in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    cnt = 0;
    while (!bus.out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    got_r = bus.r;
    check("latency", 32'(cnt), 32'(exp_lat));
    check("r", 32'(bus.r), 32'(exp_r));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dbz));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'd5;
      bus.b        = 16'd1;
      tick();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_r", 32'(bus.r), 32'(exp_r));
      check("hold_dbz", 32'(bus.div_by_zero), 32'(exp_dbz));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("in_ready_after_xfer", 32'(bus.in_ready), 32'd1);
    check("out_valid_after_xfer", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] got, er, a, b;
    logic        ed;
    logic [31:0] ra, rb;
    logic        seen;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_r", 32'(bus.r), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    run_op(16'd20,    16'd3,    R_20_3,   1'b0, LAT, 0, got);
    run_op(16'd1000,  16'd10,   16'd99,   1'b0, LAT, 0, got);
    run_op(16'd1234,  16'd0,    16'hFFFF, 1'b1, 2,   0, got);
    run_op(16'd0,     16'd7,    16'd0,    1'b0, 2,   0, got);
    run_op(16'hFFFF,  16'd1,    16'hF800, 1'b0, LAT, 0, got);
    run_op(16'd1,     16'hFFFF, 16'd0,    1'b0, LAT, 0, got);
    run_op(16'd0,     16'd0,    16'hFFFF, 1'b1, 2,   0, got);
    run_op(16'd20,    16'd3,    R_20_3,   1'b0, LAT, 5, got);

    // Reset lands while the divider is iterating; that operation must vanish.
    bus.a        = 16'd1000;
    bus.b        = 16'd10;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("no_stale_result", 32'(seen), 32'd0);
    run_op(16'd20, 16'd3, R_20_3, 1'b0, LAT, 0, got);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = $urandom_range(0, 31);
        rb = $urandom_range(0, 31);
      end else begin
        ra = $urandom & ((32'd1 << $urandom_range(0, 16)) - 32'd1);
        rb = $urandom & ((32'd1 << $urandom_range(0, 16)) - 32'd1);
      end
      a = ra[15:0];
      b = rb[15:0];
      model(a, b, er, ed);
      run_op(a, b, er, ed, (a == 16'd0 || b == 16'd0) ? 2 : LAT, $urandom_range(0, 2), got);
`ifndef DRUM_DIV_ROUND_EN
      if (a < 16'd32 && b < 16'd32 && b != 16'd0) check("exact_small", 32'(got), 32'(a / b));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
